gemm_rocc_responder: RTL and testbench

Accelerator-side end of the core-to-GEMM command handshake. Accepts a one-cycle `valid` command from the core's RoCC controller and decodes its funct and operands. Walks the output matrix tile by tile, issuing one tile job at a time to the systolic GEMM engine. Pulses `done` exactly once per accepted command so the stalled core resumes.

---
 rtl/rocc_pkg.sv | 22 ++
 rtl/tile_walker.sv | 61 ++++++
 rtl/gemm_rocc_responder.sv | 147 ++++++++++++++
 tb/tb_gemm_rocc_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rocc_pkg.sv
// Shared RoCC command definitions: funct opcodes, responder FSM states and
// the field layout of the packed dimension operand.
package rocc_pkg;

   typedef enum logic [2:0] {
      FUNCT_GEMM    = 3'b000,
      FUNCT_CLR_ERR = 3'b001
   } funct_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RUN    = 2'd2,
      ST_FINISH = 2'd3
   } resp_state_e;

   // rs2 = {ignored[31:24], M[23:16], N[15:8], K[7:0]}
   localparam int RS2_M_LSB = 16;
   localparam int RS2_N_LSB = 8;
   localparam int RS2_K_LSB = 0;

endpackage

// File: rtl/tile_walker.sv
// Row-major walk over the output matrix in TILE x TILE steps, with the
// element counts of the current (possibly partial) edge tile.
module tile_walker #(
   parameter int TILE  = 4,
   parameter int DIM_W = 8,
   parameter int CNT_W = $clog2(TILE) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             advance,
   input  logic [DIM_W-1:0] m,
   input  logic [DIM_W-1:0] n,
   output logic [DIM_W-1:0] row,
   output logic [DIM_W-1:0] col,
   output logic             last,
   output logic [CNT_W-1:0] tile_rows,
   output logic [CNT_W-1:0] tile_cols
);

   localparam logic [DIM_W:0] STEP = (DIM_W + 1)'(TILE);

   logic [DIM_W-1:0] r_row;
   logic [DIM_W-1:0] r_col;
   logic [DIM_W:0]   w_col_sum;
   logic [DIM_W:0]   w_row_sum;
   logic [DIM_W:0]   w_rem_rows;
   logic [DIM_W:0]   w_rem_cols;
   logic             w_col_wrap;

   // One extra bit keeps origin+TILE from wrapping when M or N is 255.
   always_comb begin
      w_col_sum  = {1'b0, r_col} + STEP;
      w_row_sum  = {1'b0, r_row} + STEP;
      w_col_wrap = (w_col_sum >= {1'b0, n});
      last       = w_col_wrap && (w_row_sum >= {1'b0, m});
      w_rem_rows = {1'b0, m} - {1'b0, r_row};
      w_rem_cols = {1'b0, n} - {1'b0, r_col};
      tile_rows  = (w_rem_rows >= STEP) ? CNT_W'(TILE) : CNT_W'(w_rem_rows);
      tile_cols  = (w_rem_cols >= STEP) ? CNT_W'(TILE) : CNT_W'(w_rem_cols);
   end

   // Advancing past the last tile leaves the origin alone; the job is over.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_row <= '0;
         r_col <= '0;
      end else if (advance && !last) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= DIM_W'(w_row_sum);
         end else begin
            r_col <= DIM_W'(w_col_sum);
         end
      end
   end

   assign row = r_row;
   assign col = r_col;

endmodule

// File: rtl/gemm_rocc_responder.sv
// Accelerator end of the RoCC GEMM command: decodes one command, issues
// tile jobs to the systolic engine one at a time, then pulses done once.
module gemm_rocc_responder
   import rocc_pkg::*;
#(
   parameter int TILE   = 4,
   parameter int DIM_W  = 8,
   parameter int ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid,
   input  logic [2:0]               funct,
   input  logic [ADDR_W-1:0]        rs1,
   input  logic [31:0]              rs2,
   output logic                     done,
   output logic                     busy,
   output logic                     err,
   output logic                     tile_req,
   input  logic                     tile_ack,
   input  logic                     tile_done,
   output logic [ADDR_W-1:0]        tile_base,
   output logic [DIM_W-1:0]         tile_row,
   output logic [DIM_W-1:0]         tile_col,
   output logic [DIM_W-1:0]         tile_k,
   output logic [$clog2(TILE):0]    tile_rows,
   output logic [$clog2(TILE):0]    tile_cols
);

   resp_state_e       r_state;
   resp_state_e       w_state_nxt;
   logic [ADDR_W-1:0] r_base;
   logic [DIM_W-1:0]  r_m;
   logic [DIM_W-1:0]  r_n;
   logic [DIM_W-1:0]  r_k;
   logic              r_err;

   logic [DIM_W-1:0]  w_cmd_m;
   logic [DIM_W-1:0]  w_cmd_n;
   logic [DIM_W-1:0]  w_cmd_k;
   logic              w_accept;
   logic              w_gemm_start;
   logic              w_advance;
   logic              w_last;
   logic              w_unused_rs2;

   assign w_cmd_m      = rs2[RS2_M_LSB +: DIM_W];
   assign w_cmd_n      = rs2[RS2_N_LSB +: DIM_W];
   assign w_cmd_k      = rs2[RS2_K_LSB +: DIM_W];
   assign w_unused_rs2 = ^rs2[31:24];

   // valid is only honoured in IDLE; a strobe during a job is dropped.
   assign w_accept     = (r_state == ST_IDLE) && valid;
   assign w_gemm_start = w_accept && (funct == FUNCT_GEMM);
   assign w_advance    = ((r_state == ST_ISSUE) && tile_ack && tile_done) ||
                         ((r_state == ST_RUN) && tile_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (valid) begin
               if (funct == FUNCT_GEMM && w_cmd_m != '0 && w_cmd_n != '0) begin
                  w_state_nxt = ST_ISSUE;
               end else begin
                  w_state_nxt = ST_FINISH;
               end
            end
         end
         ST_ISSUE: begin
            if (tile_ack) begin
               if (tile_done) begin
                  w_state_nxt = w_last ? ST_FINISH : ST_ISSUE;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (tile_done) begin
               w_state_nxt = w_last ? ST_FINISH : ST_ISSUE;
            end
         end
         ST_FINISH: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      tile_req = (r_state == ST_ISSUE);
      done     = (r_state == ST_FINISH);
      busy     = (r_state != ST_IDLE);
   end

   // Command latch and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base <= '0;
         r_m    <= '0;
         r_n    <= '0;
         r_k    <= '0;
         r_err  <= 1'b0;
      end else if (w_accept) begin
         if (funct == FUNCT_GEMM) begin
            r_base <= rs1;
            r_m    <= w_cmd_m;
            r_n    <= w_cmd_n;
            r_k    <= w_cmd_k;
         end else if (funct == FUNCT_CLR_ERR) begin
            r_err <= 1'b0;
         end else begin
            r_err <= 1'b1;
         end
      end
   end

   tile_walker #(
      .TILE  (TILE),
      .DIM_W (DIM_W),
      .CNT_W ($clog2(TILE) + 1)
   ) u_walker (
      .clk       (clk),
      .rst       (rst),
      .clear     (w_gemm_start),
      .advance   (w_advance),
      .m         (r_m),
      .n         (r_n),
      .row       (tile_row),
      .col       (tile_col),
      .last      (w_last),
      .tile_rows (tile_rows),
      .tile_cols (tile_cols)
   );

   assign err       = r_err;
   assign tile_base = r_base;
   assign tile_k    = r_k;

endmodule

// File: tb/tb_gemm_rocc_responder.sv
// Directed bench for gemm_rocc_responder (TILE=4): command decode, tile walk,
// edge tiles, error flag, ignored strobes and mid-job reset.
module tb_gemm_rocc_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [2:0]  funct;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        done;
   logic        busy;
   logic        err;
   logic        tile_req;
   logic        tile_ack;
   logic        tile_done;
   logic [31:0] tile_base;
   logic [7:0]  tile_row;
   logic [7:0]  tile_col;
   logic [7:0]  tile_k;
   logic [2:0]  tile_rows;
   logic [2:0]  tile_cols;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gemm_rocc_responder #(.TILE(4), .DIM_W(8), .ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .funct     (funct),
      .rs1       (rs1),
      .rs2       (rs2),
      .done      (done),
      .busy      (busy),
      .err       (err),
      .tile_req  (tile_req),
      .tile_ack  (tile_ack),
      .tile_done (tile_done),
      .tile_base (tile_base),
      .tile_row  (tile_row),
      .tile_col  (tile_col),
      .tile_k    (tile_k),
      .tile_rows (tile_rows),
      .tile_cols (tile_cols)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic e_req, input logic e_done,
                          input logic e_busy, input logic e_err);
      chk({tag, ".req"},  32'(tile_req), 32'(e_req));
      chk({tag, ".done"}, 32'(done),     32'(e_done));
      chk({tag, ".busy"}, 32'(busy),     32'(e_busy));
      chk({tag, ".err"},  32'(err),      32'(e_err));
   endtask

   task automatic chk_tile(input string tag, input logic [7:0] e_row, input logic [7:0] e_col,
                           input logic [2:0] e_rows, input logic [2:0] e_cols);
      chk({tag, ".row"},  32'(tile_row),  32'(e_row));
      chk({tag, ".col"},  32'(tile_col),  32'(e_col));
      chk({tag, ".rows"}, 32'(tile_rows), 32'(e_rows));
      chk({tag, ".cols"}, 32'(tile_cols), 32'(e_cols));
   endtask

   task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [7:0] m,
                       input logic [7:0] n, input logic [7:0] k);
      valid = 1'b1;
      funct = f;
      rs1   = a;
      rs2   = {8'hA5, m, n, k};
      tick();
      valid = 1'b0;
      funct = 3'b000;
      rs2   = 32'h0;
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; funct = 3'b000; rs1 = '0; rs2 = '0;
      tile_ack = 1'b0; tile_done = 1'b0;

      // Reset with engine handshakes toggling.
      for (int i = 0; i < 4; i++) begin
         tile_ack  = i[0];
         tile_done = ~i[0];
         tick();
         chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk_tile("rst", 8'd0, 8'd0, 3'd0, 3'd0);
      chk("rst.base", tile_base, 32'h0);
      chk("rst.k", 32'(tile_k), 32'h0);
      tile_ack = 1'b0; tile_done = 1'b0; rst = 1'b0;
      tick();
      chk_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // M=6 N=4 K=8: two tiles, second is a 2-row edge tile.
      send(3'b000, 32'h1000_0040, 8'd6, 8'd4, 8'd8);
      chk_ctl("g1.t0", 1'b1, 1'b0, 1'b1, 1'b0);
      chk_tile("g1.t0", 8'd0, 8'd0, 3'd4, 3'd4);
      chk("g1.base", tile_base, 32'h1000_0040);
      chk("g1.k", 32'(tile_k), 32'd8);
      tile_ack = 1'b1; tick(); tile_ack = 1'b0;
      chk_ctl("g1.run0", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_ctl("g1.wait0", 1'b0, 1'b0, 1'b1, 1'b0);
      tile_done = 1'b1; tick(); tile_done = 1'b0;
      chk_ctl("g1.t1", 1'b1, 1'b0, 1'b1, 1'b0);
      chk_tile("g1.t1", 8'd4, 8'd0, 3'd2, 3'd4);
      tick();
      chk_ctl("g1.hold1", 1'b1, 1'b0, 1'b1, 1'b0);
      tile_ack = 1'b1; tick(); tile_ack = 1'b0;
      chk_ctl("g1.run1", 1'b0, 1'b0, 1'b1, 1'b0);
      tile_done = 1'b1; tick(); tile_done = 1'b0;
      chk_ctl("g1.done", 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk_ctl("g1.after", 1'b0, 1'b0, 1'b0, 1'b0);

      // Zero M: done next cycle, no tile job.
      send(3'b000, 32'h2000_0000, 8'd0, 8'd4, 8'd2);
      chk_ctl("m0.done", 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk_ctl("m0.after", 1'b0, 1'b0, 1'b0, 1'b0);

      // Unsupported funct sets err; CLR_ERR clears it.
      send(3'b111, 32'h0, 8'd1, 8'd1, 8'd1);
      chk_ctl("bad.done", 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      chk_ctl("bad.after", 1'b0, 1'b0, 1'b0, 1'b1);
      send(3'b001, 32'h0, 8'd0, 8'd0, 8'd0);
      chk_ctl("clr.done", 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk_ctl("clr.after", 1'b0, 1'b0, 1'b0, 1'b0);

      // M=N=8 with ack and done together; a stray strobe mid-run is dropped.
      send(3'b000, 32'h3000_0000, 8'd8, 8'd8, 8'd4);
      chk_tile("f8.t0", 8'd0, 8'd0, 3'd4, 3'd4);
      tile_ack = 1'b1; tile_done = 1'b1;
      valid = 1'b1; funct = 3'b111; rs1 = 32'hDEAD_BEEF; rs2 = {8'h0, 8'd1, 8'd1, 8'd1};
      tick();
      valid = 1'b0; funct = 3'b000; rs2 = '0;
      chk_ctl("f8.t1", 1'b1, 1'b0, 1'b1, 1'b0);
      chk_tile("f8.t1", 8'd0, 8'd4, 3'd4, 3'd4);
      chk("f8.base", tile_base, 32'h3000_0000);
      tick();
      chk_tile("f8.t2", 8'd4, 8'd0, 3'd4, 3'd4);
      tick();
      chk_ctl("f8.t3", 1'b1, 1'b0, 1'b1, 1'b0);
      chk_tile("f8.t3", 8'd4, 8'd4, 3'd4, 3'd4);
      tick();
      chk_ctl("f8.done", 1'b0, 1'b1, 1'b1, 1'b0);
      tile_ack = 1'b0; tile_done = 1'b0;
      tick();
      chk_ctl("f8.after", 1'b0, 1'b0, 1'b0, 1'b0);

      // M=N=255: 64x64 tiles, 3-wide edges, no overflow on the last step.
      send(3'b000, 32'h4000_0000, 8'd255, 8'd255, 8'd3);
      chk_tile("big.t0", 8'd0, 8'd0, 3'd4, 3'd4);
      tile_ack = 1'b1; tile_done = 1'b1;
      for (int i = 1; i < 4096; i++) begin
         tick();
         if (i == 63) chk_tile("big.t63", 8'd0, 8'd252, 3'd4, 3'd3);
         if (i == 64) chk_tile("big.t64", 8'd4, 8'd0, 3'd4, 3'd4);
      end
      chk_ctl("big.last", 1'b1, 1'b0, 1'b1, 1'b0);
      chk_tile("big.last", 8'd252, 8'd252, 3'd3, 3'd3);
      tick();
      chk_ctl("big.done", 1'b0, 1'b1, 1'b1, 1'b0);
      tile_ack = 1'b0; tile_done = 1'b0;
      tick();
      chk_ctl("big.after", 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset at tile 10 of a 255x255 job: back to idle, no done.
      send(3'b000, 32'h5000_0000, 8'd255, 8'd255, 8'd3);
      tile_ack = 1'b1; tile_done = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk_ctl("r10.pre", 1'b1, 1'b0, 1'b1, 1'b0);
      chk_tile("r10.pre", 8'd0, 8'd40, 3'd4, 3'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_ctl("r10.rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_tile("r10.rst", 8'd0, 8'd0, 3'd0, 3'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_ctl("r10.quiet", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      tile_ack = 1'b0; tile_done = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
